// File: rtl/cmos_xclk_divgen.sv
// rtl/cmos_xclk_divgen.sv - multi-channel integer clock divider with glitch-free runtime reconfiguration
module cmos_xclk_divgen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 2,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_rise,
    output logic              LOCKED
);

    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    logic              pend_vld;
    logic [CH_W-1:0]   pend_ch;
    logic [CNT_W-1:0]  pend_div;
    logic [CNT_W-1:0]  pend_high;
    logic [NUM_CH-1:0] apply;
    logic              ch_ok;
    logic              req_legal;
    logic [LK_W-1:0]   lock_cnt;

    assign cfg_ready = ~pend_vld;

    // A power-of-two channel count makes every cfg_ch encoding valid.
    generate
        if ((1 << CH_W) == NUM_CH) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = (int'(cfg_ch) < NUM_CH);
        end
    endgenerate

    assign req_legal = ch_ok
                    && (cfg_div >= CNT_W'(2))
                    && (cfg_high != '0)
                    && (cfg_high < cfg_div);

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pend_vld  <= 1'b0;
            pend_ch   <= '0;
            pend_div  <= '0;
            pend_high <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_valid && !pend_vld && !req_legal;
            if (pend_vld) begin
                if (|apply) begin
                    pend_vld <= 1'b0;
                end
            end else if (cfg_valid && req_legal) begin
                pend_vld  <= 1'b1;
                pend_ch   <= cfg_ch;
                pend_div  <= cfg_div;
                pend_high <= cfg_high;
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            lock_cnt <= '0;
        end else if (|apply) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LK_W'(LOCK_CYCLES)) begin
            lock_cnt <= lock_cnt + LK_W'(1);
        end
    end

    assign LOCKED = (lock_cnt == LK_W'(LOCK_CYCLES));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
        logic             run;
        logic             out_q;
        logic             rise_q;
        logic             wrap;

        assign wrap     = run && (cnt == div - CNT_W'(1));
        // New settings land only at a period boundary or while idle, so no runt pulses.
        assign apply[g] = pend_vld && (pend_ch == CH_W'(g)) && (wrap || !run);

        always_ff @(posedge clk or posedge RESET) begin
            if (RESET) begin
                cnt    <= '0;
                div    <= CNT_W'(DIV_DEFAULT);
                high   <= CNT_W'(DIV_DEFAULT / 2);
                run    <= 1'b0;
                out_q  <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                if (apply[g]) begin
                    div  <= pend_div;
                    high <= pend_high;
                end
                if (run && !wrap) begin
                    cnt    <= cnt + CNT_W'(1);
                    out_q  <= (cnt + CNT_W'(1)) < high;
                    rise_q <= 1'b0;
                end else if (ch_en[g]) begin
                    // high is always >= 1, so the first cycle of a period is high.
                    cnt    <= '0;
                    run    <= 1'b1;
                    out_q  <= 1'b1;
                    rise_q <= 1'b1;
                end else begin
                    cnt    <= '0;
                    run    <= 1'b0;
                    out_q  <= 1'b0;
                    rise_q <= 1'b0;
                end
            end
        end

        assign clk_out[g]  = out_q;
        assign clk_rise[g] = rise_q;
    end

endmodule
